// File: rtl/blinker_pkg.sv
// Shared definitions for the multi-channel status blinker: channel modes,
// burst sequencer states and small helpers used by the channel logic.
package blinker_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        B_ON  = 2'd0,
        B_OFF = 2'd1,
        B_GAP = 2'd2
    } burst_state_t;

    // A half-period of zero ticks is meaningless; treat it as one tick.
    function automatic int unsigned eff_half(input int unsigned half);
        return (half == 0) ? 1 : half;
    endfunction

    // LED level a channel shows right after (re)starting in the given mode.
    function automatic logic start_led(input logic [1:0] mode, input logic cnt_nz);
        logic v;
        v = 1'b0;
        case (mode)
            MODE_ON:    v = 1'b1;
            MODE_BURST: v = cnt_nz;
            default:    v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Shared prescaler: divides the system clock by DIV and emits a registered
// one-cycle tick on each wrap. Low enable freezes the count.
module tick_prescaler #(
    parameter int unsigned DIV = 100_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tick
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Count 0..DIV-1 while enabled; tick is high the cycle after the wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_enable) begin
            if (r_cnt == CW'(DIV - 1)) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/multi_status_blinker.sv
// Multi-channel status LED driver. Each channel is OFF, ON, BLINK or BURST
// with a run-time half-period, all paced by one shared prescaler tick.
// Optional BLINKER_SYNC_EN adds i_sync_req to realign every channel's phase.
module multi_status_blinker
    import blinker_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned HALF_W     = 12,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned GAP_HALVES = 4,
    parameter int unsigned RST_HALF   = 500
) (
`ifdef BLINKER_SYNC_EN
    input  logic                                       i_sync_req,
`endif
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_enable,
    input  logic                                       i_cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_cfg_ch,
    input  logic [1:0]                                 i_cfg_mode,
    input  logic [HALF_W-1:0]                          i_cfg_half,
    input  logic [CNT_W-1:0]                           i_cfg_count,
    output logic [NUM_CH-1:0]                          o_led_out,
    output logic                                       o_tick_out
);
    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_HALVES + 1);
    localparam logic [HALF_W-1:0] RST_HALF_EFF = HALF_W'(eff_half(RST_HALF));

    logic w_sync;
    logic w_pre_rst;
    logic w_pre_tick;
    logic w_tick;

`ifdef BLINKER_SYNC_EN
    assign w_sync = i_sync_req;
`else
    assign w_sync = 1'b0;
`endif

    // A sync pulse restarts the prescaler exactly like a reset would.
    assign w_pre_rst = i_rst | w_sync;
    assign w_tick    = w_pre_tick & i_enable;
    assign o_tick_out = w_pre_tick;

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (w_pre_rst),
        .i_enable(i_enable),
        .o_tick  (w_pre_tick)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]        r_mode;
        logic [HALF_W-1:0] r_half;
        logic [HALF_W-1:0] r_phase;
        logic [CNT_W-1:0]  r_count;
        logic [CNT_W-1:0]  r_bcnt;
        logic [GAP_W-1:0]  r_gap;
        burst_state_t      r_state;
        logic              r_led;
        logic              w_wr;
        logic              w_half_evt;

        assign w_wr       = i_cfg_we && (i_cfg_ch == CH_W'(g));
        assign w_half_evt = w_tick && (r_phase == r_half - HALF_W'(1));

        // Channel state: config write beats sync, which beats the tick.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_mode  <= (g == 0) ? MODE_BLINK : MODE_OFF;
                r_half  <= (g == 0) ? RST_HALF_EFF : HALF_W'(1);
                r_count <= '0;
                r_phase <= '0;
                r_bcnt  <= '0;
                r_gap   <= '0;
                r_state <= B_ON;
                r_led   <= 1'b0;
            end else if (w_wr) begin
                r_mode  <= i_cfg_mode;
                r_half  <= HALF_W'(eff_half(32'(i_cfg_half)));
                r_count <= i_cfg_count;
                r_phase <= '0;
                r_bcnt  <= '0;
                r_gap   <= '0;
                r_state <= B_ON;
                r_led   <= start_led(i_cfg_mode, i_cfg_count != '0);
            end else if (w_sync) begin
                r_phase <= '0;
                r_bcnt  <= '0;
                r_gap   <= '0;
                r_state <= B_ON;
                r_led   <= start_led(r_mode, r_count != '0);
            end else if (w_tick) begin
                r_phase <= w_half_evt ? '0 : r_phase + HALF_W'(1);
                if (w_half_evt) begin
                    case (r_mode)
                        MODE_BLINK: r_led <= ~r_led;
                        MODE_BURST: begin
                            // A zero blink count parks the channel dark.
                            if (r_count != '0) begin
                                case (r_state)
                                    B_ON: begin
                                        r_state <= B_OFF;
                                        r_led   <= 1'b0;
                                    end
                                    B_OFF: begin
                                        if (r_bcnt == r_count - CNT_W'(1)) begin
                                            r_bcnt  <= '0;
                                            r_state <= B_GAP;
                                            r_led   <= 1'b0;
                                        end else begin
                                            r_bcnt  <= r_bcnt + CNT_W'(1);
                                            r_state <= B_ON;
                                            r_led   <= 1'b1;
                                        end
                                    end
                                    B_GAP: begin
                                        if (r_gap == GAP_W'(GAP_HALVES - 1)) begin
                                            r_gap   <= '0;
                                            r_state <= B_ON;
                                            r_led   <= 1'b1;
                                        end else begin
                                            r_gap <= r_gap + GAP_W'(1);
                                        end
                                    end
                                    default: r_state <= B_ON;
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign o_led_out[g] = r_led;
    end

endmodule
